operand_bypass: RTL
===================

Name: operand_bypass

Overview:
- Consumer end of the forwarding path. Sits in the decode/issue stage.
- Takes the registered forward records published by the EX, MEM and WB stages, together with the register-file read data.
- Selects the freshest value for each source operand.
- Detects load-use hazards and holds a stall request until the load data can be bypassed.
- Keeps a one-entry write-history buffer, so a write retired in the previous cycle is still visible while the register file is write-after-read.

Parameters:
- NSRC, 2, number of source operands resolved (rs1, rs2); fixed at 2 in this revision.
- CNT_W, 32, width of the saturating load-use stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- stall  in  1  global pipeline stall; freezes the history buffer and FSM
- rs1, rs2  in  5 each  source register addresses (creg_addr_t)
- rs1_used, rs2_used  in  1 each  operand actually read by the instruction
- rf_rdata1, rf_rdata2  in  64 each  register-file read data (word_t)
- ex_fwd, mem_fwd, wb_fwd  in  forward_data_out each  {valid, dst, data} from the EX, MEM and WB forward registers
- ex_is_load  in  1  instruction in EX is a load (its ex_fwd.data is not valid)
- mem_load_pending  in  1  load in MEM still waiting on dbus data_ok
- src1, src2  out  64 each  resolved operand values
- hit1, hit2  out  2 each  source select: 0 regfile, 1 EX, 2 MEM, 3 WB/history
- stall_req  out  1  request for the hazard unit to freeze fetch/decode
- lu_stall_cnt  out  CNT_W  count of load-use stall cycles

Behaviour:
- Reset values:
  - FSM = RUN.
  - hist.valid = 0, hist.dst = 0, hist.data = 0.
  - stall_req = 0, lu_stall_cnt = 0.
  - src/hit outputs follow the combinational rules below with every forward input invalid, so src = rf_rdata and hit = 0.
- Operand match for source k:
  - Requires src_used && rs != 0 && fwd.valid && fwd.dst == rs.
  - x0 is never forwarded; src = 0 when rs == 0.
- Priority, youngest first: EX > MEM > WB > hist > regfile. The selection is combinational (zero latency).
- EX match with ex_is_load = 1:
  - This is a load-use hazard.
  - src is don't-care, hit = 1.
  - stall_req = 1 in the same cycle.
- History buffer:
  - On a posedge with ~stall, hist <= wb_fwd.
  - hist is matched only if wb_fwd does not match.
  - When stall = 1, hist holds.
- FSM (RUN, HOLD):
  - RUN: on a load-use hazard, drive stall_req = 1 and latch pend_dst = ex_fwd.dst. The next state is HOLD regardless of stall.
  - HOLD: stall_req = 1 while (mem_fwd.dst == pend_dst && mem_load_pending) or ex_fwd still matches as a load.
  - HOLD: in the first cycle in which mem_fwd.valid && mem_fwd.dst == pend_dst && !mem_load_pending, stall_req = 0, the value is bypassed from MEM, and the next state is RUN.
  - HOLD: if pend_dst reaches WB without a MEM match (pipeline flushed), release to RUN with stall_req = 0.
- Counter:
  - lu_stall_cnt increments on every cycle with stall_req = 1.
  - It saturates at all-ones and never wraps.
- Simultaneous events:
  - rs1 == rs2 with both matching: both outputs select the same source.
  - EX and MEM both matching the same dst: EX wins.
  - A hazard on both operands counts as one stall cycle per cycle.
- Reset asserted mid-HOLD: FSM returns to RUN immediately (async), stall_req drops, and the counter clears.

Decomposition:
- Shared package pipes:
  - forward_data_out typedef (existing).
  - bypass_sel_t enum {SEL_RF, SEL_EX, SEL_MEM, SEL_WB}.
  - bypass_state_t enum {RUN, HOLD}.
- Sub-module bypass_mux:
  - Purely combinational priority select for one operand; instantiated twice.
  - Outputs value, bypass_sel_t and a load-hazard flag.
- FSM, history buffer and counter live in the top module.

Test Plan:
- rs1 = 5 used; ex_fwd = {1, 5, 0x11}; mem_fwd = {1, 5, 0x22}; ex_is_load = 0 -> src1 = 0x11, hit1 = 1, stall_req = 0.
- rs2 = 0; all forward records hit dst 0 -> src2 = 0, hit2 = 0.
- Load-use:
  - Cycle 0: ex_fwd = {1, 7, x}, ex_is_load = 1, rs1 = 7 -> stall_req = 1, FSM goes to HOLD.
  - Cycles 1-2: mem_load_pending = 1 -> stall_req = 1.
  - Cycle 3: mem_fwd = {1, 7, 0xABCD}, pending = 0 -> src1 = 0xABCD, stall_req = 0.
  - Result: lu_stall_cnt = 3.
- History: wb_fwd = {1, 9, 0x55} at edge N, then all forward records invalid with rs1 = 9 -> src1 = 0x55, hit1 = 3. With stall = 1 held across the edge, hist is unchanged.
- Reset asserted in HOLD mid-cycle -> stall_req = 0 and lu_stall_cnt = 0 before the next clock edge; FSM = RUN.
- Force lu_stall_cnt to all-ones, then hold a hazard for 2 more cycles -> counter stays at all-ones.

Source files
------------

// File: rtl/operand_bypass_pkg.sv
// Shared pipeline types for the forwarding path: forward records, bypass
// source selects and the load-use FSM state.
package pipes;

   typedef logic [4:0]  creg_addr_t;
   typedef logic [63:0] word_t;

   typedef struct packed {
      logic       valid;
      creg_addr_t dst;
      word_t      data;
   } forward_data_out;

   typedef enum logic [1:0] {SEL_RF, SEL_EX, SEL_MEM, SEL_WB} bypass_sel_t;

   typedef enum logic {RUN, HOLD} bypass_state_t;

   function automatic logic fwd_hit(input forward_data_out f, input creg_addr_t rs);
      return f.valid && (f.dst == rs);
   endfunction

endpackage

// File: rtl/operand_bypass_mux.sv
// Single-operand priority select, youngest producer first:
// EX > MEM > WB > history > register file. x0 always reads as zero.
module bypass_mux
   import pipes::*;
(
   input  creg_addr_t      i_rs,
   input  logic            i_used,
   input  word_t           i_rf_rdata,
   input  forward_data_out i_ex,
   input  forward_data_out i_mem,
   input  forward_data_out i_wb,
   input  forward_data_out i_hist,
   input  logic            i_ex_is_load,
   output word_t           o_value,
   output bypass_sel_t     o_sel,
   output logic            o_load_haz
);

   always_comb begin
      o_value    = i_rf_rdata;
      o_sel      = SEL_RF;
      o_load_haz = 1'b0;
      if (i_rs == '0) begin
         o_value = '0;
      end else if (i_used) begin
         if (fwd_hit(i_ex, i_rs)) begin
            // a load in EX has no data yet; the value is meaningless until stall clears
            o_value    = i_ex.data;
            o_sel      = SEL_EX;
            o_load_haz = i_ex_is_load;
         end else if (fwd_hit(i_mem, i_rs)) begin
            o_value = i_mem.data;
            o_sel   = SEL_MEM;
         end else if (fwd_hit(i_wb, i_rs)) begin
            o_value = i_wb.data;
            o_sel   = SEL_WB;
         end else if (fwd_hit(i_hist, i_rs)) begin
            o_value = i_hist.data;
            o_sel   = SEL_WB;
         end
      end
   end

endmodule

// File: rtl/operand_bypass.sv
// Decode-stage operand bypass: per-operand forwarding select, one-entry WB
// history, load-use stall FSM and saturating stall-cycle counter.
module operand_bypass
   import pipes::*;
#(
   parameter int NSRC  = 2,
   parameter int CNT_W = 32
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  creg_addr_t      rs1,
   input  creg_addr_t      rs2,
   input  logic            rs1_used,
   input  logic            rs2_used,
   input  word_t           rf_rdata1,
   input  word_t           rf_rdata2,
   input  forward_data_out ex_fwd,
   input  forward_data_out mem_fwd,
   input  forward_data_out wb_fwd,
   input  logic            ex_is_load,
   input  logic            mem_load_pending,
   output word_t           src1,
   output word_t           src2,
   output logic [1:0]      hit1,
   output logic [1:0]      hit2,
   output logic            stall_req,
   output logic [CNT_W-1:0] lu_stall_cnt
);

   bypass_state_t    r_state;
   creg_addr_t       r_pend_dst;
   forward_data_out  r_hist;
   logic [CNT_W-1:0] r_cnt;

   creg_addr_t       w_rs   [NSRC];
   logic             w_used [NSRC];
   word_t            w_rf   [NSRC];
   word_t            w_src  [NSRC];
   bypass_sel_t      w_sel  [NSRC];
   logic [NSRC-1:0]  w_haz_vec;
   logic             w_haz;
   logic             w_hold_stay;
   logic             w_stall_req;

   assign w_rs[0]   = rs1;
   assign w_rs[1]   = rs2;
   assign w_used[0] = rs1_used;
   assign w_used[1] = rs2_used;
   assign w_rf[0]   = rf_rdata1;
   assign w_rf[1]   = rf_rdata2;

   for (genvar k = 0; k < NSRC; k++) begin : g_src
      bypass_mux u_mux (
         .i_rs         (w_rs[k]),
         .i_used       (w_used[k]),
         .i_rf_rdata   (w_rf[k]),
         .i_ex         (ex_fwd),
         .i_mem        (mem_fwd),
         .i_wb         (wb_fwd),
         .i_hist       (r_hist),
         .i_ex_is_load (ex_is_load),
         .o_value      (w_src[k]),
         .o_sel        (w_sel[k]),
         .o_load_haz   (w_haz_vec[k])
      );
   end

   assign w_haz       = |w_haz_vec;
   assign w_hold_stay = ((mem_fwd.dst == r_pend_dst) && mem_load_pending) || w_haz;

   // Gated by reset so an async reset drops the request before the next edge.
   always_comb begin
      w_stall_req = 1'b0;
      if (!reset)
         w_stall_req = (r_state == RUN) ? w_haz : w_hold_stay;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= RUN;
         r_pend_dst <= '0;
         r_hist     <= '0;
         r_cnt      <= '0;
      end else begin
         if (w_stall_req && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
         if (!stall)
            r_hist <= wb_fwd;
         // Entering HOLD ignores the global stall; leaving it waits for it.
         case (r_state)
            RUN: begin
               if (w_haz) begin
                  r_state    <= HOLD;
                  r_pend_dst <= ex_fwd.dst;
               end
            end
            HOLD: begin
               if (!stall && !w_hold_stay)
                  r_state <= RUN;
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign src1         = w_src[0];
   assign src2         = w_src[1];
   assign hit1         = w_sel[0];
   assign hit2         = w_sel[1];
   assign stall_req    = w_stall_req;
   assign lu_stall_cnt = r_cnt;

endmodule
